alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit.sv | 123 ++++++++++++
 tb/tb_alu_issue_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// ALU issue unit: queues ALU commands in a small FIFO, issues them one at a
// time to an external combinational ALU, and holds each result until the
// consumer takes it. The last result is kept as an accumulator that a command
// may use in place of its A operand.
module alu_issue_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_use_acc,
    output logic [1:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_carry,
    output logic [3:0] acc,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e      state_q, state_d;
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [10:0] mem [DEPTH];
    logic [10:0] head;
    logic        fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q != StIdle) || !fifo_empty;

    // Next-state logic; a pop happens whenever the FSM starts a new issue.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StHold;
            StHold: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // FIFO storage: {op, a, b, use_acc}; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= {in_op, in_a, in_b, in_use_acc};
    end

    // ALU drive registers load only on issue and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_sel <= 2'd0;
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
        end else if (pop) begin
            alu_sel <= head[10:9];
            alu_a   <= head[0] ? acc : head[8:5];
            alu_b   <= head[4:1];
        end
    end

    // Result capture at the end of ISSUE; carry is only meaningful for add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= 4'd0;
            out_carry  <= 1'b0;
            acc        <= 4'd0;
        end else if (state_q == StIssue) begin
            out_valid  <= 1'b1;
            out_result <= alu_c;
            out_carry  <= (alu_sel == 2'd3) ? alu_carry : 1'b0;
            acc        <= alu_c;
        end else if (state_q == StHold && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a behavioural ALU model drives the
// ALU result inputs, and a scoreboard of expected {carry, result} values is
// filled at push time and drained when a result handshake is seen.
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_a, in_b;
    logic       in_use_acc;
    logic [1:0] alu_sel;
    logic [3:0] alu_a, alu_b;
    logic [3:0] alu_c;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic [3:0] acc;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] sb[$];
    logic [3:0] model_acc = 4'd0;
    logic       rand_done;

    alu_issue_unit #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_use_acc(in_use_acc),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_carry (alu_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .acc       (acc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream ALU; carry is forced high for logic ops so masking is visible.
    always_comb begin
        alu_c     = 4'd0;
        alu_carry = 1'b1;
        case (alu_sel)
            2'd0: alu_c = ~alu_b;
            2'd1: alu_c = alu_a & alu_b;
            2'd2: alu_c = alu_a | alu_b;
            default: {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshake completes on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_result", 8'(out_valid), 8'd0);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check_eq("result", 8'(out_result), 8'(e[3:0]));
                check_eq("carry", 8'(out_carry), 8'(e[4]));
                check_eq("acc", 8'(acc), 8'(e[3:0]));
            end
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic ua);
        logic [3:0] ea, r;
        logic [4:0] s;
        logic       c;
        int         t;
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = ua;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check_eq("push_timeout", 8'(in_ready), 8'd1);
            in_valid = 1'b0;
            return;
        end
        ea = ua ? model_acc : a;
        c  = 1'b0;
        case (op)
            2'd0: r = ~b;
            2'd1: r = ea & b;
            2'd2: r = ea | b;
            default: begin
                s = {1'b0, ea} + {1'b0, b};
                r = s[3:0];
                c = s[4];
            end
        endcase
        sb.push_back({c, r});
        model_acc = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("drain_busy", 8'(busy), 8'd0);
        check_eq("drain_sb_empty", 8'(sb.size()), 8'd0);
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("wait_valid", 8'(out_valid), 8'd1);
    endtask

    initial begin
        logic [3:0] held;
        // Reset with in_valid asserted: nothing may be queued.
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_op      = 2'd3;
        in_a       = 4'd7;
        in_b       = 4'd7;
        in_use_acc = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check_eq("rst_out_valid", 8'(out_valid), 8'd0);
        check_eq("rst_out_result", 8'(out_result), 8'd0);
        check_eq("rst_out_carry", 8'(out_carry), 8'd0);
        check_eq("rst_acc", 8'(acc), 8'd0);
        check_eq("rst_alu", {alu_sel, alu_a[1:0], alu_b}, 8'd0);
        check_eq("rst_in_ready", 8'(in_ready), 8'd1);
        check_eq("rst_busy", 8'(busy), 8'd0);
        @(posedge clk); #1;
        check_eq("rst_no_push", 8'(busy), 8'd0);

        // Single add with latency: 9 + 8 = 17 -> result 1, carry 1.
        out_ready = 1'b1;
        push_cmd(2'd3, 4'd9, 4'd8, 1'b0);
        check_eq("lat_n0_valid", 8'(out_valid), 8'd0);
        @(posedge clk); #1;
        check_eq("lat_n1_valid", 8'(out_valid), 8'd0);
        @(posedge clk); #1;
        check_eq("lat_n2_valid", 8'(out_valid), 8'd1);
        check_eq("lat_n2_result", 8'(out_result), 8'd1);
        check_eq("lat_n2_carry", 8'(out_carry), 8'd1);
        check_eq("lat_n2_acc", 8'(acc), 8'd1);
        check_eq("lat_alu_hold", {alu_sel, 6'd0}, {2'd3, 6'd0});
        wait_idle();

        // Accumulate chain: 5 + 3 = 8, then acc + 4 = 12.
        push_cmd(2'd3, 4'd5, 4'd3, 1'b0);
        push_cmd(2'd3, 4'd0, 4'd4, 1'b1);
        wait_idle();
        check_eq("chain_acc", 8'(acc), 8'd12);

        // Logic ops with the ALU carry driven high.
        push_cmd(2'd0, 4'd3, 4'hA, 1'b0);
        push_cmd(2'd1, 4'hC, 4'hA, 1'b0);
        push_cmd(2'd2, 4'hC, 4'hA, 1'b0);
        wait_idle();

        // Backpressure: one in HOLD plus DEPTH queued fills the unit.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(2'd3, 4'(i + 3), 4'(2 * i + 1), 1'b0);
        wait_valid();
        check_eq("bp_full", 8'(in_ready), 8'd0);
        held = out_result;
        repeat (10) @(posedge clk);
        #1;
        check_eq("bp_stable_result", 8'(out_result), 8'(held));
        check_eq("bp_stable_acc", 8'(acc), 8'(held));
        check_eq("bp_stable_valid", 8'(out_valid), 8'd1);
        check_eq("bp_still_full", 8'(in_ready), 8'd0);
        out_ready = 1'b1;
        wait_idle();

        // Simultaneous push and pop at occupancy 2.
        out_ready = 1'b0;
        push_cmd(2'd3, 4'd1, 4'd1, 1'b0);
        push_cmd(2'd2, 4'd2, 4'd4, 1'b0);
        push_cmd(2'd1, 4'hF, 4'h6, 1'b0);
        wait_valid();
        out_ready = 1'b1;
        push_cmd(2'd0, 4'd0, 4'h3, 1'b0);
        out_ready = 1'b0;
        check_eq("pp_occ2_ready", 8'(in_ready), 8'd1);
        push_cmd(2'd3, 4'd0, 4'd7, 1'b1);
        check_eq("pp_occ3_ready", 8'(in_ready), 8'd1);
        push_cmd(2'd3, 4'hE, 4'hE, 1'b0);
        check_eq("pp_occ4_full", 8'(in_ready), 8'd0);
        out_ready = 1'b1;
        wait_idle();

        // Random stream with random backpressure to exercise pointer wrap.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    push_cmd(2'($urandom_range(3)), 4'($urandom_range(15)),
                             4'($urandom_range(15)), 1'($urandom_range(1)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(1));
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();

        // Reset while holding a result with two commands queued.
        out_ready = 1'b0;
        push_cmd(2'd3, 4'd2, 4'd2, 1'b0);
        push_cmd(2'd3, 4'd3, 4'd3, 1'b0);
        push_cmd(2'd3, 4'd4, 4'd4, 1'b0);
        wait_valid();
        rst_n = 1'b0;
        sb.delete();
        model_acc = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("mid_rst_valid", 8'(out_valid), 8'd0);
        check_eq("mid_rst_acc", 8'(acc), 8'd0);
        check_eq("mid_rst_ready", 8'(in_ready), 8'd1);
        check_eq("mid_rst_busy", 8'(busy), 8'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_rst_quiet", 8'(out_valid), 8'd0);
        check_eq("mid_rst_quiet_busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
